// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN classification back end.
package cnn_pkg;

    localparam int DEFAULT_NUM_CLASSES = 10;
    localparam int DEFAULT_SCORE_W     = 32;
    localparam int DEFAULT_IDX_W       = 4;

    typedef logic [DEFAULT_IDX_W-1:0]          class_idx_t;
    typedef logic signed [DEFAULT_SCORE_W-1:0] score_t;

    // Result class code shown while no frame has completed since reset.
    localparam class_idx_t CLASS_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } argmax_state_t;

endpackage

// File: rtl/cnn_argmax_unit_if.sv
// Score stream, result handshake and status signals of the argmax unit.
interface cnn_argmax_unit_if #(
    parameter int SCORE_W = cnn_pkg::DEFAULT_SCORE_W,
    parameter int IDX_W   = cnn_pkg::DEFAULT_IDX_W
);
    logic                      start;
    logic                      score_valid;
    logic                      score_ready;
    logic signed [SCORE_W-1:0] score_data;
    logic                      score_last;
    logic                      busy;
    logic                      result_valid;
    logic                      result_ready;
    logic [IDX_W-1:0]          result_class;
    logic signed [SCORE_W-1:0] result_score;
    logic signed [SCORE_W-1:0] runner_up_score;
    logic                      err_len;

    modport slave (
        input  start, score_valid, score_data, score_last, result_ready,
        output score_ready, busy, result_valid, result_class, result_score,
               runner_up_score, err_len
    );

    modport master (
        output start, score_valid, score_data, score_last, result_ready,
        input  score_ready, busy, result_valid, result_class, result_score,
               runner_up_score, err_len
    );

endinterface

// File: rtl/cnn_argmax_unit_top2_update.sv
// Combinational best/runner-up update for one incoming score.
module top2_update #(
    parameter int SCORE_W = cnn_pkg::DEFAULT_SCORE_W,
    parameter int IDX_W   = cnn_pkg::DEFAULT_IDX_W
) (
    input  logic signed [SCORE_W-1:0] best,
    input  logic signed [SCORE_W-1:0] runner_up,
    input  logic [IDX_W-1:0]          best_idx,
    input  logic signed [SCORE_W-1:0] score,
    input  logic [IDX_W-1:0]          beat_idx,
    output logic signed [SCORE_W-1:0] next_best,
    output logic signed [SCORE_W-1:0] next_runner_up,
    output logic [IDX_W-1:0]          next_best_idx
);

    // Strict greater-than keeps the lowest index on ties and lets the tie fill the runner-up.
    always_comb begin
        next_best      = best;
        next_runner_up = runner_up;
        next_best_idx  = best_idx;
        if (score > best) begin
            next_runner_up = best;
            next_best      = score;
            next_best_idx  = beat_idx;
        end else if (score > runner_up) begin
            next_runner_up = score;
        end
    end

endmodule

// File: rtl/cnn_argmax_unit.sv
// Streaming argmax: tracks best and runner-up scores per frame and holds the result.
module cnn_argmax_unit
    import cnn_pkg::*;
#(
    parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
    parameter int SCORE_W     = DEFAULT_SCORE_W,
    parameter int IDX_W       = DEFAULT_IDX_W
) (
    input logic               clk,
    input logic               rst,
    cnn_argmax_unit_if.slave  bus
);

    localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

    argmax_state_t state;
    argmax_state_t next_state;

    logic                      score_ready;
    logic                      busy;
    logic                      result_valid;
    logic                      accept;
    logic                      final_beat;
    logic                      len_error;

    logic [IDX_W-1:0]          beat_cnt;
    logic signed [SCORE_W-1:0] best;
    logic signed [SCORE_W-1:0] runner_up;
    logic [IDX_W-1:0]          best_idx;

    logic signed [SCORE_W-1:0] next_best;
    logic signed [SCORE_W-1:0] next_runner_up;
    logic [IDX_W-1:0]          next_best_idx;

    logic [IDX_W-1:0]          res_class;
    logic signed [SCORE_W-1:0] res_score;
    logic signed [SCORE_W-1:0] res_runner_up;
    logic                      res_err;

    assign accept     = bus.score_valid && (state == COLLECT);
    assign final_beat = bus.score_last || (beat_cnt == LAST_IDX);
    // A frame is well formed only when score_last lands exactly on the last class.
    assign len_error  = bus.score_last != (beat_cnt == LAST_IDX);

    top2_update #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_top2_update (
        .best           (best),
        .runner_up      (runner_up),
        .best_idx       (best_idx),
        .score          (bus.score_data),
        .beat_idx       (beat_cnt),
        .next_best      (next_best),
        .next_runner_up (next_runner_up),
        .next_best_idx  (next_best_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        score_ready  = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                score_ready = 1'b1;
                busy        = 1'b1;
                if (accept && final_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                if (bus.result_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Working registers are reloaded at frame start; result registers only change on the final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt      <= '0;
            best          <= MOST_NEG;
            runner_up     <= MOST_NEG;
            best_idx      <= '0;
            res_class     <= '1;
            res_score     <= '0;
            res_runner_up <= '0;
            res_err       <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                beat_cnt  <= '0;
                best      <= MOST_NEG;
                runner_up <= MOST_NEG;
                best_idx  <= '0;
            end
            if (accept) begin
                beat_cnt  <= beat_cnt + 1'b1;
                best      <= next_best;
                runner_up <= next_runner_up;
                best_idx  <= next_best_idx;
                if (final_beat) begin
                    res_class     <= next_best_idx;
                    res_score     <= next_best;
                    res_runner_up <= next_runner_up;
                    res_err       <= len_error;
                end
            end
        end
    end

    assign bus.score_ready     = score_ready;
    assign bus.busy            = busy;
    assign bus.result_valid    = result_valid;
    assign bus.result_class    = res_class;
    assign bus.result_score    = res_score;
    assign bus.runner_up_score = res_runner_up;
    assign bus.err_len         = res_err;

endmodule

// File: tb/tb_cnn_argmax_unit.sv
// Scoreboard bench for cnn_argmax_unit: frames push expectations, results pop and compare.
module tb_cnn_argmax_unit;

    localparam int NC = 10;
    localparam int SW = 32;
    localparam int IW = 4;
    localparam logic signed [SW-1:0] MOST_NEG = {1'b1, {(SW-1){1'b0}}};

    typedef struct {
        logic [IW-1:0]        cls;
        logic signed [SW-1:0] score;
        logic signed [SW-1:0] runner;
        logic                 err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    cnn_argmax_unit_if #(.SCORE_W(SW), .IDX_W(IW)) bus ();

    cnn_argmax_unit #(
        .NUM_CLASSES (NC),
        .SCORE_W     (SW),
        .IDX_W       (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   check_count = 0;
    int   error_count = 0;
    exp_t sb[$];
    int   frame[NC];

    int f_main[NC]  = '{3, -1, 0, 9, 2, 9, 5, -7, 1, 4};
    int f_neg[NC]   = '{-10, -3, -8, -5, -20, -4, -9, -7, -6, -11};
    int f_next[NC]  = '{5, 1, 7, 7, -2, 0, 3, 6, 2, 1};
    int f_hold[NC]  = '{100, 200, 50, -300, 260, 250, 10, 0, -1, 199};
    int f_nolst[NC] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    int f_post[NC]  = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, 0};

    task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input int cls, input int s, input int r, input bit e);
        exp_t x;
        x.cls    = IW'(cls);
        x.score  = s;
        x.runner = r;
        x.err    = e;
        return x;
    endfunction

    // Reference top-2 search over beats 0..end_k of the current frame.
    function automatic exp_t modelFrame(input int end_k, input bit e);
        exp_t x;
        x.cls    = '0;
        x.score  = MOST_NEG;
        x.runner = MOST_NEG;
        x.err    = e;
        for (int k = 0; k <= end_k; k++) begin
            if (frame[k] > x.score) begin
                x.runner = x.score;
                x.score  = frame[k];
                x.cls    = IW'(k);
            end else if (frame[k] > x.runner) begin
                x.runner = frame[k];
            end
        end
        return x;
    endfunction

    task automatic loadFrame(input int v[NC]);
        for (int k = 0; k < NC; k++) frame[k] = v[k];
    endtask

    // Called at a negedge; drives start, streams beats up to the final one, pushes the expectation.
    task automatic applyStimulus(input int last_pos, input int bubble_pct, input exp_t e);
        int  end_k;
        int  k;
        int  guard;
        bit  vld;
        bit  accepted;
        end_k = (last_pos >= 0 && last_pos < NC) ? last_pos : NC - 1;
        sb.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("ready_after_start", bus.score_ready, 1);
        k     = 0;
        guard = 0;
        while (k <= end_k && guard < 500) begin
            vld = ($urandom_range(0, 99) >= bubble_pct);
            bus.score_valid = vld;
            bus.score_data  = frame[k];
            bus.score_last  = (k == last_pos);
            accepted = vld && bus.score_ready;
            @(negedge clk);
            guard++;
            if (accepted) k++;
        end
        bus.score_valid = 1'b0;
        bus.score_last  = 1'b0;
        if (guard >= 500) checkOutput("beat_timeout", 0, 1);
        checkOutput("result_latency", bus.result_valid, 1);
    endtask

    // Waits for a result, compares against the scoreboard, optionally backpressures, then accepts.
    task automatic getResult(input int hold);
        exp_t e;
        int   g;
        g = 0;
        while (!bus.result_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!bus.result_valid) begin
            checkOutput("result_timeout", 0, 1);
            return;
        end
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        checkOutput("result_class", bus.result_class, e.cls);
        checkOutput("result_score", bus.result_score, e.score);
        checkOutput("runner_up", bus.runner_up_score, e.runner);
        checkOutput("err_len", bus.err_len, e.err);
        for (int i = 0; i < hold; i++) begin
            bus.score_valid = 1'($urandom_range(0, 1));
            bus.start       = 1'($urandom_range(0, 1));
            bus.score_data  = $urandom;
            @(negedge clk);
            checkOutput("hold_valid", bus.result_valid, 1);
            checkOutput("hold_ready", bus.score_ready, 0);
            checkOutput("hold_class", bus.result_class, e.cls);
            checkOutput("hold_score", bus.result_score, e.score);
            checkOutput("hold_runner", bus.runner_up_score, e.runner);
        end
        bus.score_valid  = 1'b0;
        bus.result_ready = 1'b1;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        bus.start        = 1'b0;
        checkOutput("idle_valid", bus.result_valid, 0);
        checkOutput("idle_busy", bus.busy, 0);
        checkOutput("idle_keep_class", bus.result_class, e.cls);
    endtask

    initial begin
        exp_t e;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.score_valid  = 1'b0;
        bus.score_data   = '0;
        bus.score_last   = 1'b0;
        bus.result_ready = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", bus.score_ready, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_valid", bus.result_valid, 0);
        checkOutput("rst_err", bus.err_len, 0);
        checkOutput("rst_class", bus.result_class, cnn_pkg::CLASS_NONE);
        checkOutput("rst_score", bus.result_score, 0);
        checkOutput("rst_runner", bus.runner_up_score, 0);
        rst = 1'b0;
        @(negedge clk);

        loadFrame(f_main);
        applyStimulus(9, 0, mkExp(3, 9, 9, 1'b0));
        getResult(0);

        loadFrame(f_neg);
        applyStimulus(9, 0, mkExp(1, -3, -4, 1'b0));
        getResult(0);

        for (int k = 0; k < NC; k++) frame[k] = k;
        applyStimulus(5, 0, mkExp(5, 5, 4, 1'b1));
        getResult(0);

        loadFrame(f_next);
        applyStimulus(9, 0, mkExp(2, 7, 7, 1'b0));
        getResult(0);

        loadFrame(f_hold);
        applyStimulus(9, 0, mkExp(4, 260, 250, 1'b0));
        getResult(20);

        loadFrame(f_nolst);
        applyStimulus(-1, 0, mkExp(9, 10, 9, 1'b1));
        getResult(0);

        for (int k = 0; k < NC; k++) begin
            frame[k] = $urandom;
            if (frame[k] == 32'h7FFF_FFFF) frame[k] = 0;
        end
        frame[8] = 32'h7FFF_FFFF;
        e = modelFrame(NC - 1, 1'b0);
        checkOutput("bubble_model_class", e.cls, 8);
        applyStimulus(9, 40, e);
        getResult(0);

        // Reset in the middle of a frame: beats 0..3 accepted, reset during beat 4.
        loadFrame(f_main);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.score_valid = 1'b1;
            bus.score_data  = frame[k];
            @(negedge clk);
        end
        bus.score_data = frame[4];
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_ready", bus.score_ready, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_valid", bus.result_valid, 0);
        checkOutput("midrst_class", bus.result_class, cnn_pkg::CLASS_NONE);
        checkOutput("midrst_score", bus.result_score, 0);
        checkOutput("midrst_runner", bus.runner_up_score, 0);
        checkOutput("midrst_err", bus.err_len, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.score_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("postrst_novalid", bus.result_valid, 0);
        end

        loadFrame(f_post);
        applyStimulus(9, 0, mkExp(9, 0, -1, 1'b0));
        getResult(0);

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/cnn_argmax_unit.md
# cnn_argmax_unit

Sequential classification stage that sits directly downstream of the fully-connected layer. It accepts the per-class scores as a valid/ready stream, one score per cycle, and tracks the best and second-best scores. It then presents the winning class index, its score, and the runner-up score through a held valid/ready result interface. It replaces the combinational all-class sort with a single comparator pipeline.

## Interface
Parameters:
- NUM_CLASSES, 10, number of scores per frame (≥2)
- SCORE_W, 32, score width; scores are two's-complement signed
- IDX_W, 4, class index width; requires 2^IDX_W > NUM_CLASSES

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begins a frame; honoured only in IDLE
- score_valid  in  1  score_data is valid this cycle
- score_ready  out  1  unit accepts a score this cycle
- score_data  in  SCORE_W  signed score for class = beat index
- score_last  in  1  marks the final beat of a frame
- busy  out  1  high in COLLECT and DONE
- result_valid  out  1  result fields valid; held until accepted
- result_ready  in  1  downstream accepts the result
- result_class  out  IDX_W  argmax class index
- result_score  out  SCORE_W  maximum score
- runner_up_score  out  SCORE_W  second-highest score
- err_len  out  1  frame length differed from NUM_CLASSES; qualified by result_valid

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE → COLLECT on start.
  - On entry, beat counter ← 0, best ← most-negative value, runner-up ← most-negative value, best index ← 0, error ← 0.
- COLLECT:
  - score_ready = 1.
  - A beat is accepted when score_valid && score_ready.
  - For each accepted beat at index k:
    - If score > best: runner-up ← best, best ← score, best index ← k.
    - Else if score > runner-up: runner-up ← score.
    - The compare is strictly greater than, so on a tie the lowest index wins and the runner-up equals the tie value.
- COLLECT → DONE on the accepted beat where score_last = 1 or k = NUM_CLASSES-1, whichever comes first.
  - err_len ← 1 if score_last arrives with k < NUM_CLASSES-1.
  - err_len ← 1 if k = NUM_CLASSES-1 arrives without score_last.
- DONE:
  - result_valid = 1 and all result fields are stable.
  - On result_valid && result_ready, go to IDLE.
  - Result fields keep their values in IDLE until the next frame completes.
- start is ignored outside IDLE.
- score_valid is ignored outside COLLECT; score_ready = 0 outside COLLECT.
- Signed compare is performed at full SCORE_W; no saturation or truncation.

## Timing
- Reset values:
  - State IDLE.
  - score_ready 0, busy 0, result_valid 0, err_len 0.
  - result_class = all ones (4'hF, the "no result" code).
  - result_score 0, runner_up_score 0.
- start in cycle t → score_ready high in cycle t+1.
- Throughput: one score per cycle; a full frame takes NUM_CLASSES cycles of COLLECT when there are no bubbles.
- Latency: final beat accepted in cycle t → result_valid and results registered by the edge ending cycle t, visible in cycle t+1.
- Backpressure: result_valid with result_ready low holds DONE indefinitely with all fields stable.
- result_valid && result_ready in cycle t → IDLE in t+1.
  - start sampled in cycle t is ignored.
  - start is honoured from cycle t+1, so a new frame can have score_ready high in cycle t+2.
- Reset asserted mid-frame clears everything asynchronously; the partial frame is discarded and no result is produced.

## Structure
- Shared package cnn_pkg holds:
  - NUM_CLASSES and SCORE_W defaults;
  - typedef class_idx_t (IDX_W bits);
  - typedef score_t (signed SCORE_W);
  - constant CLASS_NONE = 4'hF;
  - enum argmax_state_t {IDLE, COLLECT, DONE}.
- One sub-module is natural: top2_update.
  - Purely combinational.
  - Inputs: current best, runner-up, best index, new score, beat index.
  - Outputs: next best, next runner-up, next best index.
  - The FSM and registers stay in cnn_argmax_unit.

## Test plan
- Frame 3,−1,0,9,2,9,5,−7,1,4 with score_last on beat 9 → result_class 3, result_score 9, runner_up_score 9, err_len 0, result_valid one cycle after beat 9.
- All scores negative (−10,−3,−8,…) → result_class 1, result_score −3; confirms the signed compare.
- score_last on beat 5 of scores 0..5 → result_class 5, runner_up_score 4, err_len 1; a following 10-beat frame has err_len 0.
- Hold result_ready low for 20 cycles, toggle score_valid and start, then raise result_ready → fields unchanged during the hold, score_ready stays 0, IDLE one cycle after acceptance.
- score_valid toggled randomly within a frame whose maximum 0x7FFFFFFF is at beat 8 → result_class 8 regardless of bubbles.
- Assert rst during beat 4 of a frame → all outputs return to reset values immediately (result_class 4'hF); the next full frame produces a correct result.
